// File: rtl/cache_backing_mem.sv
// Purpose     : backing-memory responder for a cache line refill/writeback port.
// Latency     : first refill beat is valid LATENCY cycles after acceptance; writeback completes when the last beat lands.
// Backpressure: one request at a time (req_ready only in IDLE); refill has none; writeback stalls on wdata_valid low.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset (also reinitialises memory)
//   req_valid/req_ready        line request handshake; req_we, req_addr sampled at acceptance
//   wdata/wdata_valid/ready    writeback beats, critical word first
//   rdata/rdata_valid          registered refill beats, critical word first
//   wr_done                    one-cycle pulse after the last writeback beat
//   busy                       responder is not idle
module cache_backing_mem #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int BURST   = 2,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wr_done,
    output logic              busy
);

    localparam int DEPTH      = 2 ** ADDR_W;
    localparam int OFF_W      = $clog2(BURST);
    localparam int LINE_W     = ADDR_W - OFF_W;
    // A line index of zero bits still needs a storage bit; it is truncated away in the address.
    localparam int LINE_STORE = (LINE_W > 0) ? LINE_W : 1;
    localparam int BEAT_W     = OFF_W + 1;
    localparam int LAT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [LAT_W-1:0]  LAT_INIT   = LAT_W'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST - 1);
    localparam logic [BEAT_W-1:0] BEAT_END   = BEAT_W'(BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RBURST,
        S_WBURST,
        S_DONE
    } state_t;

    state_t                  state;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [LINE_STORE-1:0]   line_q;
    logic [OFF_W-1:0]        off_q;
    logic                    we_q;
    logic [BEAT_W-1:0]       beat;
    logic [LAT_W-1:0]        lat_cnt;
    logic [OFF_W-1:0]        beat_off;
    logic [ADDR_W-1:0]       mem_idx;

    // Offset addition is OFF_W bits wide so it wraps inside the line and
    // never carries into the line index.
    always_comb begin
        beat_off = off_q + beat[OFF_W-1:0];
        mem_idx  = ADDR_W'({line_q, beat_off});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            line_q      <= '0;
            off_q       <= '0;
            we_q        <= 1'b0;
            beat        <= '0;
            lat_cnt     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            wr_done     <= 1'b0;
            busy        <= 1'b0;
            wdata_ready <= 1'b0;
            req_ready   <= 1'b1;
            // Reset restores the known init pattern, discarding any partial writeback.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'($unsigned(i) ^ 32'h0000_00A5);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        line_q    <= LINE_STORE'(req_addr >> OFF_W);
                        off_q     <= req_addr[OFF_W-1:0];
                        we_q      <= req_we;
                        beat      <= '0;
                        lat_cnt   <= LAT_INIT;
                        state     <= S_WAIT;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end else if (!we_q) begin
                        // Leaving WAIT already registers the critical word.
                        state       <= S_RBURST;
                        rdata       <= mem[mem_idx];
                        rdata_valid <= 1'b1;
                        beat        <= beat + BEAT_W'(1);
                    end else begin
                        state       <= S_WBURST;
                        wdata_ready <= 1'b1;
                    end
                end
                S_RBURST: begin
                    if (beat == BEAT_END) begin
                        rdata_valid <= 1'b0;
                        state       <= S_IDLE;
                        req_ready   <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        rdata <= mem[mem_idx];
                        beat  <= beat + BEAT_W'(1);
                    end
                end
                S_WBURST: begin
                    if (wdata_valid) begin
                        mem[mem_idx] <= wdata;
                        beat         <= beat + BEAT_W'(1);
                        if (beat == BEAT_LAST) begin
                            state       <= S_DONE;
                            wdata_ready <= 1'b0;
                            wr_done     <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    wr_done   <= 1'b0;
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
